// File: rtl/mdu_pkg.sv
// Shared definitions for the MDU issue path: op-class encodings, controller
// state encoding and op-class helpers.
package mdu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] MDU_NONE = 4'd0;
    localparam logic [OP_W-1:0] MULT     = 4'd1;
    localparam logic [OP_W-1:0] MULTU    = 4'd2;
    localparam logic [OP_W-1:0] DIV      = 4'd3;
    localparam logic [OP_W-1:0] DIVU     = 4'd4;
    localparam logic [OP_W-1:0] MFHI     = 4'd5;
    localparam logic [OP_W-1:0] MFLO     = 4'd6;
    localparam logic [OP_W-1:0] MTHI     = 4'd7;
    localparam logic [OP_W-1:0] MTLO     = 4'd8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUED = 2'd1,
        BUSY   = 2'd2
    } mdu_state_e;

    function automatic logic is_compute(input logic [OP_W-1:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_move_from(input logic [OP_W-1:0] op);
        return (op == MFHI) || (op == MFLO);
    endfunction

    function automatic logic is_move_to(input logic [OP_W-1:0] op);
        return (op == MTHI) || (op == MTLO);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; async active-low clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mdu_issue_ctrl.sv
// E-stage issue/hazard controller for the MDU Start/Busy handshake.
//
// state  | meaning
// IDLE   | no op in flight; a COMPUTE in E may launch
// ISSUED | Start sampled last cycle, waiting for the MDU to raise Busy
// BUSY   | MDU computing; lat_cnt counts Busy cycles for the timeout
module mdu_issue_ctrl #(
    parameter int OP_W    = 4,
    parameter int MAX_LAT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [OP_W-1:0]  d_op,
    input  logic             e_valid,
    input  logic [OP_W-1:0]  e_op,
    input  logic             req,
    input  logic             mdu_busy,
    output logic             mdu_start,
    output logic [OP_W-1:0]  mdu_op,
    output logic             stall_d,
    output logic             proto_err,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cnt
);

    import mdu_pkg::*;

    localparam int LAT_W = $clog2(MAX_LAT + 1);

    mdu_state_e       state;
    logic [LAT_W-1:0] lat_cnt;
    logic             idle;

    assign idle      = (state == IDLE);
    assign mdu_start = e_valid & is_compute(e_op) & ~req & idle;
    assign mdu_op    = (e_valid & ~req & idle) ? e_op : OP_W'(MDU_NONE);
    // The MDU raises Busy a cycle after Start, so the Start cycle itself must stall.
    assign stall_d   = d_valid & (d_op != OP_W'(MDU_NONE))
                     & (~idle | mdu_busy | mdu_start);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            proto_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else if (!req) begin
            case (state)
                IDLE: begin
                    if (mdu_start) begin
                        state   <= ISSUED;
                        lat_cnt <= '0;
                    end
                end
                ISSUED: begin
                    if (mdu_busy) begin
                        state   <= BUSY;
                        lat_cnt <= LAT_W'(1);
                    end else begin
                        state     <= IDLE;
                        proto_err <= 1'b1;
                    end
                end
                BUSY: begin
                    if (!mdu_busy) begin
                        state <= IDLE;
                    end else if (lat_cnt == LAT_W'(MAX_LAT - 1)) begin
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr_n (reset),
        .en    (stall_d),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: stub MDU plus an op-level reference model.
module tb_mdu_issue_ctrl;

    localparam int OP_W    = 4;
    localparam int MAX_LAT = 16;
    localparam int CNT_W   = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [3:0] OP_NONE = 4'd0, OP_MULT = 4'd1, OP_DIVU = 4'd4,
                           OP_MFLO = 4'd6, OP_MTHI = 4'd7;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             d_valid = 1'b0, e_valid = 1'b0, req = 1'b0;
    logic [OP_W-1:0]  d_op = '0, e_op = '0;
    logic             mdu_busy;
    logic             mdu_start, stall_d, proto_err, timeout_err;
    logic [OP_W-1:0]  mdu_op;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    mdu_issue_ctrl #(.OP_W(OP_W), .MAX_LAT(MAX_LAT), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .d_valid     (d_valid),
        .d_op        (d_op),
        .e_valid     (e_valid),
        .e_op        (e_op),
        .req         (req),
        .mdu_busy    (mdu_busy),
        .mdu_start   (mdu_start),
        .mdu_op      (mdu_op),
        .stall_d     (stall_d),
        .proto_err   (proto_err),
        .timeout_err (timeout_err),
        .stall_cnt   (stall_cnt)
    );

    // Stub MDU: mode 0 = mult 5 / div 10 Busy cycles, 1 = never busy, 2 = busy forever.
    int stub_mode = 0;
    bit stub_clr  = 1'b0;
    int rem = 0;
    always @(posedge clk) begin
        if (stub_clr) rem <= 0;
        else if (!req) begin
            if (mdu_start && stub_mode == 0) rem <= (mdu_op == 4'd1 || mdu_op == 4'd2) ? 5 : 10;
            else if (mdu_start && stub_mode == 2) rem <= 1000000;
            else if (rem > 0) rem <= rem - 1;
        end
    end
    assign mdu_busy = (rem != 0);

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: an op is in flight from Start until Busy drops, until the MDU
    // fails to respond right after Start, or until Busy has been seen MAX_LAT times.
    bit m_infl, m_wait, m_perr, m_terr;
    int m_busyn, m_cnt, obs_starts;

    function automatic bit is_cmp(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd4);
    endfunction

    task automatic model_clear();
        m_infl = 0; m_wait = 0; m_perr = 0; m_terr = 0; m_busyn = 0; m_cnt = 0;
    endtask

    task automatic step(input bit dv, input logic [3:0] dop, input bit ev,
                        input logic [3:0] eop, input bit rq);
        bit exp_start, exp_stall;
        logic [3:0] exp_op;
        int exp_phase;
        @(negedge clk);
        d_valid = dv; d_op = dop; e_valid = ev; e_op = eop; req = rq;
        #1;
        exp_start = ev && is_cmp(eop) && !rq && !m_infl;
        exp_op    = (ev && !rq && !m_infl) ? eop : OP_NONE;
        exp_stall = dv && (dop != OP_NONE) && (m_infl || mdu_busy || exp_start);
        exp_phase = !m_infl ? 0 : (m_wait ? 1 : 2);
        check("start", 32'(mdu_start), 32'(exp_start));
        check("op", 32'(mdu_op), 32'(exp_op));
        check("stall", 32'(stall_d), 32'(exp_stall));
        check("proto_err", 32'(proto_err), 32'(m_perr));
        check("timeout_err", 32'(timeout_err), 32'(m_terr));
        check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        check("state", 32'(dut.state), 32'(exp_phase));
        if (mdu_start) obs_starts++;
        if (exp_stall && m_cnt < CNT_MAX) m_cnt++;
        if (!rq) begin
            if (!m_infl) begin
                if (exp_start) begin m_infl = 1; m_wait = 1; m_busyn = 0; end
            end else if (!mdu_busy) begin
                if (m_wait) m_perr = 1;
                m_infl = 0;
            end else begin
                m_wait = 0;
                m_busyn++;
                if (m_busyn == MAX_LAT) begin m_infl = 0; m_terr = 1; end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        d_valid = 0; e_valid = 0; req = 0; d_op = '0; e_op = '0;
        stub_clr = 1; reset = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1; stub_clr = 0;
        model_clear();
        obs_starts = 0;
    endtask

    initial begin
        model_clear();
        obs_starts = 0;
        do_reset();
        step(0, OP_NONE, 0, OP_NONE, 0);

        // mult in E with mflo waiting in D: 7 stall cycles
        step(1, OP_MFLO, 1, OP_MULT, 0);
        repeat (8) step(1, OP_MFLO, 0, OP_NONE, 0);
        check("mult_stall_total", 32'(stall_cnt), 32'd7);
        check("mult_start_pulses", 32'(obs_starts), 32'd1);

        // divu then mult back-to-back
        do_reset();
        step(1, OP_MULT, 1, OP_DIVU, 0);
        repeat (11) step(1, OP_MULT, 0, OP_NONE, 0);
        step(0, OP_NONE, 1, OP_MULT, 0);
        repeat (8) step(0, OP_NONE, 0, OP_NONE, 0);
        check("b2b_start_pulses", 32'(obs_starts), 32'd2);
        check("b2b_stall_total", 32'(stall_cnt), 32'd12);

        // req held 3 cycles while BUSY, MTHI in E must not reach the MDU
        do_reset();
        step(1, OP_MFLO, 1, OP_MULT, 0);
        repeat (2) step(1, OP_MFLO, 0, OP_NONE, 0);
        repeat (3) step(1, OP_MFLO, 1, OP_MTHI, 1);
        repeat (8) step(1, OP_MFLO, 0, OP_NONE, 0);
        check("req_stall_total", 32'(stall_cnt), 32'd10);
        check("req_no_err", 32'({proto_err, timeout_err}), 32'd0);

        // MDU never raises Busy
        do_reset();
        stub_mode = 1;
        step(0, OP_NONE, 1, OP_MULT, 0);
        step(0, OP_NONE, 0, OP_NONE, 0);
        step(0, OP_NONE, 0, OP_NONE, 0);
        check("proto_err_set", 32'(proto_err), 32'd1);
        repeat (4) step(0, OP_NONE, 0, OP_NONE, 0);
        check("proto_err_sticky", 32'(proto_err), 32'd1);

        // MDU holds Busy forever
        do_reset();
        stub_mode = 2;
        step(0, OP_NONE, 1, OP_DIVU, 0);
        repeat (17) step(0, OP_NONE, 0, OP_NONE, 0);
        check("timeout_set", 32'(timeout_err), 32'd1);
        check("timeout_idle", 32'(dut.state), 32'd0);

        // async reset mid-BUSY, then a normal mult
        do_reset();
        stub_mode = 0;
        step(1, OP_MFLO, 1, OP_MULT, 0);
        repeat (3) step(1, OP_MFLO, 0, OP_NONE, 0);
        #2;
        d_valid = 0; e_valid = 0;
        reset = 0;
        #1;
        check("rst_start", 32'(mdu_start), 32'd0);
        check("rst_op", 32'(mdu_op), 32'd0);
        check("rst_stall", 32'(stall_d), 32'd0);
        check("rst_errs", 32'({proto_err, timeout_err}), 32'd0);
        check("rst_cnt", 32'(stall_cnt), 32'd0);
        check("rst_state", 32'(dut.state), 32'd0);
        #1;
        reset = 1;
        model_clear();
        repeat (4) step(1, OP_MFLO, 0, OP_NONE, 0);
        step(1, OP_MFLO, 1, OP_MULT, 0);
        repeat (8) step(1, OP_MFLO, 0, OP_NONE, 0);
        check("post_rst_no_perr", 32'(proto_err), 32'd0);

        // random traffic
        do_reset();
        stub_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 1), 4'($urandom_range(0, 8)),
                 $urandom_range(0, 1), 4'($urandom_range(0, 8)),
                 ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- Issue and hazard controller on the E-stage side of the multiply/divide unit's Start/Busy handshake.
- Decides when a compute op is launched and drives Start and the op code to the MDU.
- Tracks the in-flight operation, including the one-cycle gap before the MDU raises Busy, and stalls the D stage for any dependent MDU instruction.
- Flags protocol errors and timeouts, and counts stall cycles.

Parameters:
- OP_W, 4, width of MDU op code (encodings in shared package).
- MAX_LAT, 16, cycles in BUSY before timeout is declared (must exceed 10).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- d_valid  in  1  D stage holds a valid instruction.
- d_op  in  OP_W  MDU op class of the D-stage instruction.
- e_valid  in  1  E stage holds a valid instruction.
- e_op  in  OP_W  MDU op class of the E-stage instruction.
- req  in  1  exception/interrupt entry; the MDU freezes while high.
- mdu_busy  in  1  Busy from MDU.
- mdu_start  out  1  Start to MDU.
- mdu_op  out  OP_W  op code to MDU.
- stall_d  out  1  freeze PC/F/D and insert a bubble into E.
- proto_err  out  1  sticky: MDU failed to raise Busy after Start.
- timeout_err  out  1  sticky: Busy held for MAX_LAT cycles.
- stall_cnt  out  CNT_W  saturating count of cycles with stall_d=1.

Behaviour:
- Op classes:
  - COMPUTE = mult, multu, div, divu.
  - MOVE_TO = mthi, mtlo.
  - MOVE_FROM = mfhi, mflo.
  - NONE = non-MDU instruction.
- State register: IDLE, ISSUED, BUSY. Reset (reset=0, asynchronous) forces IDLE, lat_cnt=0, proto_err=0, timeout_err=0, stall_cnt=0.
- mdu_start (combinational) = e_valid & COMPUTE(e_op) & ~req & state==IDLE.
- mdu_op (combinational) = e_op when e_valid & ~req & state==IDLE; otherwise NONE.
- stall_d (combinational) = d_valid & d_op!=NONE & (state!=IDLE | mdu_busy | mdu_start).
  - This covers the Start cycle, because the MDU raises Busy one cycle after sampling Start.
- Transitions, evaluated only when req=0. While req=1, state, lat_cnt and the error flags hold.
  - IDLE -> ISSUED when mdu_start=1. lat_cnt<=0.
  - ISSUED -> BUSY when mdu_busy=1. lat_cnt<=1.
  - ISSUED -> IDLE when mdu_busy=0. Set proto_err.
  - BUSY -> IDLE when mdu_busy=0. The result is visible in HI/LO this cycle.
  - BUSY with mdu_busy=1: lat_cnt<=lat_cnt+1. When lat_cnt==MAX_LAT-1, go to IDLE and set timeout_err.
- Latency contract:
  - mult/multu: Busy high for 5 cycles, then 1 cycle of IDLE-recovery.
  - div/divu: Busy high for 10 cycles.
  - The controller must not depend on these values; it follows mdu_busy.
- stall_cnt increments on every rising clk with stall_d=1 and saturates at all-ones. Wrap-around is forbidden.
- Simultaneous events:
  - req rising in the same cycle as an E-stage COMPUTE: no Start, state stays IDLE.
  - MOVE_TO in E while BUSY: mdu_op=NONE. The instruction is already held in D by the stall, so nothing is lost.
  - Back-to-back COMPUTE: the second one waits in D until state returns to IDLE and mdu_busy=0.
- Reset mid-operation (any state): immediate return to IDLE. A later mdu_busy=1 seen in IDLE does not set proto_err; stall_d still covers it.

Decomposition:
- Shared package mdu_pkg:
  - OP_W.
  - Op encodings: MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8.
  - State encoding, IDLE=0, ISSUED=1, BUSY=2.
  - Functions is_compute / is_move_from / is_move_to.
- One sub-module: sat_counter (parameterised width, enable, asynchronous active-low clear), used for stall_cnt.

Test Plan:
- mult with D1=3, D2=-2 in E, mflo in D:
  - mdu_start=1 for exactly 1 cycle.
  - state IDLE->ISSUED->BUSY.
  - stall_d high through the last Busy cycle, 7 cycles total; stall_cnt=7.
  - mflo proceeds when mdu_busy falls and reads 0xFFFFFFFA.
- divu followed by mult back-to-back:
  - The second Start is asserted only after mdu_busy=0.
  - Exactly 2 Start pulses.
  - stall_d continuous until the second issue.
- req=1 held 3 cycles while BUSY:
  - state and lat_cnt frozen; no Start.
  - Completion follows 3 cycles later than it would without req.
  - No errors.
- Stub MDU that never raises Busy after Start: proto_err=1 two cycles after Start, state=IDLE, flag stays set.
- Stub MDU holding Busy forever with MAX_LAT=16: timeout_err=1 after 16 BUSY cycles, state returns to IDLE.
- reset pulsed low mid-BUSY, asynchronously between clock edges: all outputs 0 immediately and state IDLE; a subsequent mult issues normally.
